// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the USB receiver/transmitter and the AHB-lite slave.
// One storage array, one pair of wrapping pointers, registered read ports and sticky error flags.
module usb_data_buffer #(
  parameter int DEPTH = 64,
  parameter int OCC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clear,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  output logic [7:0]       rx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [7:0]       mem_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       tx_pkt_q, tx_pkt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PW-1:0]    count_s;
  logic             empty_s, full_s, empty_req_s;
  logic             wr_s, rd_s, rd_ok_s, wr_ok_s, wr_collide_s, mem_we_s;
  logic [7:0]       wr_byte_s, head_s;

  // Request decode and acceptance; a read on a full buffer frees the slot a same-cycle write uses.
  always_comb begin
    count_s      = wptr_q - rptr_q;
    empty_s      = (count_s == {PW{1'b0}});
    full_s       = (count_s == FULL_CNT);
    empty_req_s  = flush | clear;
    wr_s         = store_rx_packet_data | store_tx_data;
    rd_s         = get_rx_data | get_tx_packet_data;
    wr_collide_s = store_rx_packet_data & store_tx_data;
    rd_ok_s      = rd_s & ~empty_s;
    wr_ok_s      = wr_s & (~full_s | rd_ok_s);
    mem_we_s     = wr_ok_s & ~empty_req_s;
    head_s       = mem_q[rptr_q[AW-1:0]];
    if (store_rx_packet_data) begin
      wr_byte_s = rx_packet_data;
    end else begin
      wr_byte_s = tx_data;
    end
  end

  // Next-state for pointers, occupancy, read ports and sticky errors.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rx_data_d = rx_data_q;
    tx_pkt_d  = tx_pkt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (empty_req_s) begin
      wptr_d    = {PW{1'b0}};
      rptr_d    = {PW{1'b0}};
      rx_data_d = 8'h00;
      tx_pkt_d  = 8'h00;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_ok_s) begin
        rptr_d = rptr_q + PTR_ONE;
        if (get_rx_data) begin
          rx_data_d = head_s;
        end else begin
          rx_data_d = rx_data_q;
        end
        if (get_tx_packet_data) begin
          tx_pkt_d = head_s;
        end else begin
          tx_pkt_d = tx_pkt_q;
        end
      end else begin
        rptr_d = rptr_q;
      end
      ovf_d = ovf_q | wr_collide_s | (wr_s & ~wr_ok_s);
      unf_d = unf_q | (rd_s & empty_s);
    end
    occ_d = OCC_W'(wptr_d - rptr_d);
  end

  // State registers; storage array is deliberately left out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= {PW{1'b0}};
      rptr_q    <= {PW{1'b0}};
      occ_q     <= {OCC_W{1'b0}};
      rx_data_q <= 8'h00;
      tx_pkt_q  <= 8'h00;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      rx_data_q <= rx_data_d;
      tx_pkt_q  <= tx_pkt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Byte storage write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wptr_q[AW-1:0]] <= wr_byte_s;
    end
  end

  assign rx_data          = rx_data_q;
  assign tx_packet_data   = tx_pkt_q;
  assign buffer_occupancy = occ_q;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed self-checking bench for usb_data_buffer (DEPTH 64).
module tb_usb_data_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, clear;
  logic       store_rx_packet_data, store_tx_data;
  logic [7:0] rx_packet_data, tx_data;
  logic       get_rx_data, get_tx_packet_data;
  logic [7:0] rx_data, tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       overflow_err, underflow_err;

  int n_checks = 0;
  int n_fails  = 0;

  usb_data_buffer #(.DEPTH(64), .OCC_W(7)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    store_rx_packet_data = 1'b1;
    rx_packet_data       = b;
    step();
    store_rx_packet_data = 1'b0;
  endtask

  task automatic pop_rx();
    get_rx_data = 1'b1;
    step();
    get_rx_data = 1'b0;
  endtask

  task automatic pop_tx();
    get_tx_packet_data = 1'b1;
    step();
    get_tx_packet_data = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_occ"}, 32'(buffer_occupancy), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    check_eq({tag, "_unf"}, 32'(underflow_err), 32'd0);
    check_eq({tag, "_rx"}, 32'(rx_data), 32'h00);
    check_eq({tag, "_tx"}, 32'(tx_packet_data), 32'h00);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clear = 1'b0;
    store_rx_packet_data = 1'b0; store_tx_data = 1'b0;
    rx_packet_data = 8'h00; tx_data = 8'h00;
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
    #12;
    check_idle_zero("reset");
    step();
    rst = 1'b0;
    step();

    // basic fill / read
    push_rx(8'hA5);
    check_eq("basic_occ1", 32'(buffer_occupancy), 32'd1);
    pop_rx();
    check_eq("basic_rx", 32'(rx_data), 32'hA5);
    check_eq("basic_occ0", 32'(buffer_occupancy), 32'd0);
    check_eq("basic_ovf", 32'(overflow_err), 32'd0);
    check_eq("basic_unf", 32'(underflow_err), 32'd0);

    // ordering and pointer wrap
    for (int i = 0; i < 64; i++) push_rx(8'(i));
    check_eq("wrap_full", 32'(buffer_occupancy), 32'd64);
    for (int i = 0; i < 64; i++) begin
      pop_rx();
      check_eq("wrap_rd", 32'(rx_data), 32'(i));
    end
    for (int i = 0; i < 10; i++) push_rx(8'(8'h40 + i));
    check_eq("wrap_occ10", 32'(buffer_occupancy), 32'd10);
    for (int i = 0; i < 10; i++) begin
      pop_rx();
      check_eq("wrap_rd2", 32'(rx_data), 32'(8'h40 + i));
    end
    check_eq("wrap_occ0", 32'(buffer_occupancy), 32'd0);
    check_eq("wrap_ovf", 32'(overflow_err), 32'd0);

    // full / overflow
    for (int i = 0; i < 64; i++) push_rx(8'(8'h50 + i));
    check_eq("full_occ", 32'(buffer_occupancy), 32'd64);
    push_rx(8'hFF);
    check_eq("full_drop_occ", 32'(buffer_occupancy), 32'd64);
    check_eq("full_drop_ovf", 32'(overflow_err), 32'd1);
    store_tx_data = 1'b1; tx_data = 8'hEE; get_tx_packet_data = 1'b1;
    step();
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0;
    check_eq("full_rw_tx", 32'(tx_packet_data), 32'h50);
    check_eq("full_rw_occ", 32'(buffer_occupancy), 32'd64);
    for (int i = 0; i < 63; i++) begin
      pop_tx();
      check_eq("full_drain", 32'(tx_packet_data), 32'(8'h51 + i));
    end
    pop_tx();
    check_eq("full_last_EE", 32'(tx_packet_data), 32'hEE);
    check_eq("full_end_occ", 32'(buffer_occupancy), 32'd0);
    check_eq("full_sticky_ovf", 32'(overflow_err), 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check_eq("flush_ovf_clr", 32'(overflow_err), 32'd0);

    // empty / underflow
    push_rx(8'h77);
    pop_tx();
    check_eq("unf_tx_pre", 32'(tx_packet_data), 32'h77);
    pop_tx();
    check_eq("unf_flag", 32'(underflow_err), 32'd1);
    check_eq("unf_tx_hold", 32'(tx_packet_data), 32'h77);
    check_eq("unf_occ", 32'(buffer_occupancy), 32'd0);
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h11; get_rx_data = 1'b1;
    step();
    store_rx_packet_data = 1'b0; get_rx_data = 1'b0;
    check_eq("unf_rw_occ", 32'(buffer_occupancy), 32'd1);
    check_eq("unf_rw_flag", 32'(underflow_err), 32'd1);
    check_eq("unf_rw_nobypass", 32'(rx_data), 32'h00);
    pop_rx();
    check_eq("unf_rw_rd", 32'(rx_data), 32'h11);
    check_eq("unf_rw_occ0", 32'(buffer_occupancy), 32'd0);

    // write / read collisions
    flush = 1'b1; step(); flush = 1'b0;
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h22;
    store_tx_data = 1'b1; tx_data = 8'h33;
    step();
    store_rx_packet_data = 1'b0; store_tx_data = 1'b0;
    check_eq("coll_occ", 32'(buffer_occupancy), 32'd1);
    check_eq("coll_ovf", 32'(overflow_err), 32'd1);
    get_rx_data = 1'b1; get_tx_packet_data = 1'b1;
    step();
    get_rx_data = 1'b0; get_tx_packet_data = 1'b0;
    check_eq("coll_rx", 32'(rx_data), 32'h22);
    check_eq("coll_tx", 32'(tx_packet_data), 32'h22);
    check_eq("coll_occ0", 32'(buffer_occupancy), 32'd0);
    check_eq("coll_unf", 32'(underflow_err), 32'd0);

    // flush priority
    pop_rx();
    for (int i = 1; i <= 5; i++) push_rx(8'(i));
    check_eq("fl_pre_occ", 32'(buffer_occupancy), 32'd5);
    check_eq("fl_pre_ovf", 32'(overflow_err), 32'd1);
    check_eq("fl_pre_unf", 32'(underflow_err), 32'd1);
    flush = 1'b1; store_rx_packet_data = 1'b1; rx_packet_data = 8'h99; get_rx_data = 1'b1;
    step();
    flush = 1'b0; store_rx_packet_data = 1'b0; get_rx_data = 1'b0;
    check_idle_zero("flush");
    pop_rx();
    check_eq("flush_absent_rx", 32'(rx_data), 32'h00);
    check_eq("flush_absent_unf", 32'(underflow_err), 32'd1);

    // clear priority
    for (int i = 1; i <= 5; i++) push_rx(8'(8'h60 + i));
    store_rx_packet_data = 1'b1; rx_packet_data = 8'h66;
    store_tx_data = 1'b1; tx_data = 8'h67;
    step();
    store_rx_packet_data = 1'b0; store_tx_data = 1'b0;
    pop_tx();
    check_eq("cl_pre_occ", 32'(buffer_occupancy), 32'd5);
    check_eq("cl_pre_ovf", 32'(overflow_err), 32'd1);
    check_eq("cl_pre_tx", 32'(tx_packet_data), 32'h61);
    clear = 1'b1; store_tx_data = 1'b1; tx_data = 8'h98; get_tx_packet_data = 1'b1;
    step();
    clear = 1'b0; store_tx_data = 1'b0; get_tx_packet_data = 1'b0;
    check_idle_zero("clear");
    step();
    check_eq("clear_absent_occ", 32'(buffer_occupancy), 32'd0);

    // asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) push_rx(8'(8'hC0 + i));
    pop_tx();
    check_eq("ar_pre_tx", 32'(tx_packet_data), 32'hC0);
    store_rx_packet_data = 1'b1; rx_packet_data = 8'hC4;
    step();
    check_eq("ar_pre_occ", 32'(buffer_occupancy), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("async_rst");
    store_rx_packet_data = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_eq("ar_post_occ", 32'(buffer_occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
